// File: rtl/hls_deadlock_report_arbiter.sv
// Debounces per-monitor HLS deadlock flags and reports each confirmed episode round-robin
// on a single valid/ready channel. Optional confirmation timestamps: DEADLOCK_REPORT_TS_EN.
module hls_deadlock_report_arbiter #(
    parameter int NUM_MON     = 4,
    parameter int ID_W        = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 5
`ifdef DEADLOCK_REPORT_TS_EN
    ,
    parameter int TS_W        = 32
`endif
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_MON-1:0] mon_block,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [ID_W-1:0]    report_id,
    output logic [NUM_MON-1:0] report_pending,
    output logic               any_deadlock
`ifdef DEADLOCK_REPORT_TS_EN
    ,
    output logic [TS_W-1:0]    report_ts
`endif
);

    typedef enum logic [1:0] {IDLE, REPORT, GAP} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt [NUM_MON];
    logic [NUM_MON-1:0] armed;
    logic [NUM_MON-1:0] pending;
    logic [NUM_MON-1:0] confirm;
    logic [NUM_MON-1:0] clear_mask;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    hi_id;
    logic [ID_W-1:0]    lo_id;
    logic               pick_hi;
    logic               handshake;
    logic               load_report;

    // A flag confirms on the edge that completes HOLD_CYCLES consecutive enabled-high samples,
    // but only once per episode: armed re-arms only after the flag drops.
    always_comb begin
        confirm = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            confirm[i] = mon_block[i] && enable && armed[i] && (cnt[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_MON; i++) begin
                cnt[i] <= '0;
            end
            armed <= '1;
        end else begin
            for (int i = 0; i < NUM_MON; i++) begin
                if (!enable || !mon_block[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != HOLD_MAX) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (!mon_block[i]) begin
                    armed[i] <= 1'b1;
                end else if (confirm[i]) begin
                    armed[i] <= 1'b0;
                end
            end
        end
    end

    assign handshake   = (state == REPORT) && report_ready;
    assign load_report = (state == IDLE) && (pending != '0);

    always_comb begin
        clear_mask = '0;
        if (handshake) begin
            clear_mask[report_id] = 1'b1;
        end
    end

    // A new confirmation wins over a handshake clear of the same bit: it is a fresh episode.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clear_mask) | confirm;
        end
    end

    // Round-robin: lowest set bit above the pointer, else lowest set bit at or below it.
    always_comb begin
        pick_hi = 1'b0;
        hi_id   = '0;
        lo_id   = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (pending[i]) begin
                if (ID_W'(i) > rr_ptr) begin
                    hi_id   = ID_W'(i);
                    pick_hi = 1'b1;
                end else begin
                    lo_id = ID_W'(i);
                end
            end
        end
        pick_id = pick_hi ? hi_id : lo_id;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr    <= ID_W'(NUM_MON - 1);
            report_id <= '0;
        end else begin
            if (load_report) begin
                report_id <= pick_id;
            end
            if (handshake) begin
                rr_ptr <= report_id;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending != '0) state_next = REPORT;
            REPORT:  if (report_ready) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        report_valid = (state == REPORT);
    end

    assign report_pending = pending;
    assign any_deadlock   = |pending;

`ifdef DEADLOCK_REPORT_TS_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_cap [NUM_MON];

    // report_ts is latched alongside report_id so a re-confirmation cannot disturb it mid-report.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt    <= '0;
            report_ts <= '0;
            for (int i = 0; i < NUM_MON; i++) begin
                ts_cap[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            for (int i = 0; i < NUM_MON; i++) begin
                if (confirm[i]) begin
                    ts_cap[i] <= ts_cnt;
                end
            end
            if (load_report) begin
                report_ts <= ts_cap[pick_id];
            end
        end
    end
`endif

endmodule
